// File: rtl/vpe_scheduler.sv
// Vector processing-element scheduler: accepts a vector command, fetches operands per
// element, runs the PE under a watchdog and writes each result back in index order.
module vpe_scheduler #(
    parameter int VLMAX   = 64,
    parameter int TIMEOUT = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_instr,
    input  logic [7:0]  cmd_vl,
    input  logic [9:0]  cmd_sew,
    input  logic [3:0]  cmd_vap,
    output logic        busy,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        rd_req,
    output logic [7:0]  rd_idx,
    input  logic        rd_valid,
    input  logic [31:0] rd_opa,
    input  logic [31:0] rd_opb,
    input  logic [31:0] rd_opc,
    output logic        pe_reset_n,
    output logic        pe_start,
    input  logic        pe_done,
    output logic [7:0]  pe_instr,
    output logic [9:0]  pe_sew,
    output logic [3:0]  pe_vap,
    output logic [31:0] pe_opa,
    output logic [31:0] pe_opb,
    output logic [31:0] pe_opc,
    input  logic [31:0] pe_out,
    output logic        wb_valid,
    output logic [7:0]  wb_idx,
    output logic [31:0] wb_data
);

    localparam int         WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [7:0] VLMAX_B = 8'(VLMAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_OPS = 3'd2,
        EXEC     = 3'd3,
        WB       = 3'd4,
        FINISH   = 3'd5
    } state_t;

    state_t          state_r;
    logic [7:0]      index_r;
    logic [7:0]      vl_r;
    logic            done_q_r;
    logic            finish_err_r;
    logic [WD_W-1:0] wd_r;
    logic            completion_s;

    // Rejects opcodes outside the table, unsupported element widths, and lane-parallel
    // opcodes without a legal lane count.
    function automatic logic cmd_bad(input logic [7:0] instr, input logic [9:0] sew,
                                     input logic [3:0] vap);
        logic sew_ok;
        logic vap_needed;
        logic vap_ok;
        sew_ok     = (sew == 10'd8) || (sew == 10'd16) || (sew == 10'd32);
        vap_needed = (instr == 8'h03) || (instr == 8'h04) || (instr == 8'h05) || (instr == 8'h07);
        vap_ok     = (vap == 4'd1) || (vap == 4'd2) || (vap == 4'd4);
        return (instr > 8'h07) || !sew_ok || (vap_needed && !vap_ok);
    endfunction

    // A pe_done still high from the previous element is masked by done_q.
    assign completion_s = pe_done & ~done_q_r;
    assign pe_start     = (state_r == EXEC) & ~completion_s & ~reset;

    // Command sequencing FSM with registered status, fetch, PE and writeback outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= 8'd0;
            vl_r         <= 8'd0;
            done_q_r     <= 1'b0;
            finish_err_r <= 1'b0;
            wd_r         <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            cmd_done     <= 1'b0;
            cmd_err      <= 1'b0;
            rd_req       <= 1'b0;
            rd_idx       <= 8'd0;
            pe_reset_n   <= 1'b0;
            pe_instr     <= 8'd0;
            pe_sew       <= 10'd0;
            pe_vap       <= 4'd0;
            pe_opa       <= 32'd0;
            pe_opb       <= 32'd0;
            pe_opc       <= 32'd0;
            wb_valid     <= 1'b0;
            wb_idx       <= 8'd0;
            wb_data      <= 32'd0;
        end else begin
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
            rd_req     <= 1'b0;
            wb_valid   <= 1'b0;
            pe_reset_n <= 1'b1;
            done_q_r   <= pe_done;
            case (state_r)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_bad(cmd_instr, cmd_sew, cmd_vap)) begin
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b1;
                        end else begin
                            pe_instr     <= cmd_instr;
                            pe_sew       <= cmd_sew;
                            pe_vap       <= cmd_vap;
                            vl_r         <= cmd_vl;
                            index_r      <= 8'd0;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                            finish_err_r <= (cmd_vl > VLMAX_B);
                            if ((cmd_vl == 8'd0) || (cmd_vl > VLMAX_B)) begin
                                state_r <= FINISH;
                            end else begin
                                state_r <= FETCH;
                                rd_req  <= 1'b1;
                                rd_idx  <= 8'd0;
                            end
                        end
                    end
                end
                FETCH: begin
                    state_r <= WAIT_OPS;
                end
                WAIT_OPS: begin
                    if (rd_valid) begin
                        pe_opa  <= rd_opa;
                        pe_opb  <= rd_opb;
                        pe_opc  <= rd_opc;
                        wd_r    <= '0;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (completion_s) begin
                        wb_data  <= pe_out;
                        wb_valid <= 1'b1;
                        wb_idx   <= index_r;
                        state_r  <= WB;
                    end else if (wd_r == WD_LAST) begin
                        // Hung PE: reset it and abort the whole command.
                        pe_reset_n <= 1'b0;
                        cmd_err    <= 1'b1;
                        cmd_done   <= 1'b1;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        wd_r <= wd_r + 1'b1;
                    end
                end
                WB: begin
                    if (index_r == vl_r - 8'd1) begin
                        state_r <= FINISH;
                    end else begin
                        index_r <= index_r + 8'd1;
                        rd_req  <= 1'b1;
                        rd_idx  <= index_r + 8'd1;
                        state_r <= FETCH;
                    end
                end
                FINISH: begin
                    cmd_done  <= 1'b1;
                    cmd_err   <= finish_err_r;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpe_scheduler.sv
// Self-checking bench for vpe_scheduler: operand memory and PE models drive the DUT,
// a monitor logs its activity and each command is scored against a rule-based model.
module tb_vpe_scheduler;

    localparam int VLMAX   = 64;
    localparam int TIMEOUT = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_instr, cmd_vl;
    logic [9:0]  cmd_sew;
    logic [3:0]  cmd_vap;
    logic        busy, cmd_done, cmd_err;
    logic        rd_req, rd_valid;
    logic [7:0]  rd_idx;
    logic [31:0] rd_opa, rd_opb, rd_opc;
    logic        pe_reset_n, pe_start, pe_done;
    logic [7:0]  pe_instr;
    logic [9:0]  pe_sew;
    logic [3:0]  pe_vap;
    logic [31:0] pe_opa, pe_opb, pe_opc, pe_out;
    logic        wb_valid;
    logic [7:0]  wb_idx;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_c [256];
    int rd_lat = 1;
    int pe_lat = 1;
    bit pe_enable = 1'b1;
    bit pe_hold = 1'b0;

    int          rd_q [$];
    int          wb_q_idx [$];
    logic [31:0] wb_q_data [$];
    int          wb_q_cyc [$];
    int          done_cnt, done_cyc, acc_cyc, accept_cnt, start_cnt, prn_cnt, stray_err;
    logic        done_err;

    vpe_scheduler #(.VLMAX(VLMAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_vl(cmd_vl), .cmd_sew(cmd_sew), .cmd_vap(cmd_vap),
        .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_opa(rd_opa), .rd_opb(rd_opb), .rd_opc(rd_opc),
        .pe_reset_n(pe_reset_n), .pe_start(pe_start), .pe_done(pe_done),
        .pe_instr(pe_instr), .pe_sew(pe_sew), .pe_vap(pe_vap),
        .pe_opa(pe_opa), .pe_opb(pe_opb), .pe_opc(pe_opc), .pe_out(pe_out),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane-wise PE operation on sew-bit lanes: 0 add, 1 mul, 2 sub, 3 and-or, else xor3.
    function automatic logic [31:0] lane_op(input logic [7:0] op, input logic [9:0] sew,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        logic [31:0] r, m, x, y, z, v;
        int w;
        w = int'(sew);
        if (w != 8 && w != 16) w = 32;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r = 32'd0;
        for (int sh = 0; sh < 32; sh += w) begin
            x = (a >> sh) & m;
            y = (b >> sh) & m;
            z = (c >> sh) & m;
            case (op)
                8'd0:    v = x + y;
                8'd1:    v = x * y;
                8'd2:    v = x - y;
                8'd3:    v = (x & y) | z;
                default: v = x ^ y ^ z;
            endcase
            r |= (v & m) << sh;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_q.delete(); wb_q_idx.delete(); wb_q_data.delete(); wb_q_cyc.delete();
        done_cnt = 0; done_cyc = 0; acc_cyc = 0; accept_cnt = 0;
        start_cnt = 0; prn_cnt = 0; stray_err = 0; done_err = 1'b0;
    endtask

    // Operand memory: answers each rd_req rd_lat cycles later, junk on the bus otherwise.
    initial begin
        int ridx;
        rd_valid = 1'b0; rd_opa = 32'd0; rd_opb = 32'd0; rd_opc = 32'd0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            rd_opa = $urandom; rd_opb = $urandom; rd_opc = $urandom;
            if (rd_req && !reset) begin
                ridx = int'(rd_idx);
                repeat (rd_lat) @(negedge clk);
                rd_opa = mem_a[ridx]; rd_opb = mem_b[ridx]; rd_opc = mem_c[ridx];
                rd_valid = 1'b1;
            end
        end
    end

    // PE model: raises pe_done pe_lat cycles after start; in hold mode done stays high.
    initial begin
        int cnt;
        cnt = 0; pe_done = 1'b0; pe_out = 32'd0;
        forever begin
            @(negedge clk);
            if (!pe_reset_n || !pe_enable) begin
                pe_done = 1'b0; cnt = 0;
            end else if (pe_start) begin
                cnt++;
                if (pe_hold && cnt == 2) pe_done = 1'b0;
                else if (!pe_hold) pe_done = 1'b0;
                if (cnt == pe_lat + 1) begin
                    pe_out = lane_op(pe_instr, pe_sew, pe_opa, pe_opb, pe_opc);
                    pe_done = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (!pe_hold) pe_done = 1'b0;
            end
        end
    end

    // Monitor: samples settled DUT activity shortly after each falling edge.
    initial begin
        clear_log();
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (cmd_valid && cmd_ready) begin acc_cyc = cyc; accept_cnt++; end
                if (rd_req) rd_q.push_back(int'(rd_idx));
                if (wb_valid) begin
                    wb_q_idx.push_back(int'(wb_idx));
                    wb_q_data.push_back(wb_data);
                    wb_q_cyc.push_back(cyc);
                end
                if (cmd_done) begin done_cnt++; done_err = cmd_err; done_cyc = cyc; end
                if (cmd_err && !cmd_done) stray_err++;
                if (pe_start) start_cnt++;
                if (!pe_reset_n) prn_cnt++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_err"}, {30'd0, cmd_done, cmd_err}, 32'd0);
        chk({tag, "_rd"}, {23'd0, rd_req, rd_idx}, 32'd0);
        chk({tag, "_pe_ctl"}, {9'd0, pe_start, pe_instr, pe_sew, pe_vap}, 32'd0);
        chk({tag, "_pe_ops"}, pe_opa | pe_opb | pe_opc, 32'd0);
        chk({tag, "_wb"}, {23'd0, wb_valid, wb_idx}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_pe_reset_n"}, {31'd0, pe_reset_n}, 32'd0);
    endtask

    task automatic issue(input logic [7:0] instr, input logic [7:0] vl,
                         input logic [9:0] sew, input logic [3:0] vap);
        for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_instr = instr; cmd_vl = vl; cmd_sew = sew; cmd_vap = vap;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] instr, input logic [7:0] vl, input logic [9:0] sew,
                           input logic [3:0] vap, input int rl, input int pl,
                           input bit rand_mem, input bit garbage, input bit tmo);
        bit bad;
        logic exp_err;
        int exp_wb, exp_rd, exp_start, exp_prn, exp_delay, elen, n;
        if (rand_mem) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = $urandom; mem_b[i] = $urandom; mem_c[i] = $urandom;
            end
        end
        rd_lat = rl; pe_lat = pl; pe_enable = !tmo;
        @(negedge clk);
        clear_log();
        issue(instr, vl, sew, vap);
        if (garbage) begin
            repeat (3) @(negedge clk);
            cmd_valid = 1'b1; cmd_instr = 8'h09; cmd_vl = 8'd1;
            repeat (8) @(negedge clk);
            cmd_valid = 1'b0;
        end
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);

        bad = (instr > 8'h07) || !(sew == 10'd8 || sew == 10'd16 || sew == 10'd32) ||
              ((instr == 8'h03 || instr == 8'h04 || instr == 8'h05 || instr == 8'h07) &&
               !(vap == 4'd1 || vap == 4'd2 || vap == 4'd4));
        elen = 3 + rl + pl;
        exp_wb = 0; exp_rd = 0; exp_start = 0; exp_prn = 0;
        if (bad) begin
            exp_err = 1'b1; exp_delay = 1;
        end else if (vl == 8'd0 || int'(vl) > VLMAX) begin
            exp_err = (int'(vl) > VLMAX); exp_delay = 2;
        end else if (tmo) begin
            exp_err = 1'b1; exp_delay = 2 + rl + TIMEOUT;
            exp_rd = 1; exp_start = TIMEOUT; exp_prn = 1;
        end else begin
            exp_err = 1'b0; exp_delay = int'(vl) * elen + 2;
            exp_rd = int'(vl); exp_wb = int'(vl); exp_start = int'(vl) * pl;
        end

        chk("accept_count", accept_cnt, 1);
        chk("done_count", done_cnt, 1);
        chk("done_err", {31'd0, done_err}, {31'd0, exp_err});
        chk("done_delay", done_cyc - acc_cyc, exp_delay);
        chk("stray_err", stray_err, 0);
        chk("rd_count", rd_q.size(), exp_rd);
        chk("wb_count", wb_q_idx.size(), exp_wb);
        chk("pe_start_cycles", start_cnt, exp_start);
        chk("pe_reset_pulses", prn_cnt, exp_prn);
        n = (rd_q.size() < exp_rd) ? rd_q.size() : exp_rd;
        for (int i = 0; i < n; i++) chk($sformatf("rd_idx[%0d]", i), rd_q[i], i);
        n = (wb_q_idx.size() < exp_wb) ? wb_q_idx.size() : exp_wb;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("wb_idx[%0d]", i), wb_q_idx[i], i);
            chk($sformatf("wb_data[%0d]", i), wb_q_data[i],
                lane_op(instr, sew, mem_a[i], mem_b[i], mem_c[i]));
            chk($sformatf("wb_cycle[%0d]", i), wb_q_cyc[i] - acc_cyc, (i + 1) * elen);
        end
        pe_enable = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] sews [7];
        logic [7:0] r_instr, r_vl;
        sews = '{10'd8, 10'd16, 10'd32, 10'd8, 10'd16, 10'd32, 10'd12};
        reset = 1'b1; cmd_valid = 1'b0;
        cmd_instr = 8'd0; cmd_vl = 8'd0; cmd_sew = 10'd0; cmd_vap = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // vadd sew=8 over three identical words
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0102_0304; mem_b[i] = 32'h0101_0101; mem_c[i] = 32'h0;
        end
        run_cmd(8'h00, 8'd3, 10'd8, 4'd1, 1, 1, 1'b0, 1'b0, 1'b0);
        if (wb_q_data.size() > 0) chk("vadd_word0", wb_q_data[0], 32'h0203_0405);

        // vmul sew=32 with a multi-cycle PE
        mem_a[0] = 32'd5; mem_b[0] = 32'd7;
        run_cmd(8'h01, 8'd1, 10'd32, 4'd1, 2, 4, 1'b0, 1'b0, 1'b0);
        if (wb_q_data.size() > 0) chk("vmul_word0", wb_q_data[0], 32'd35);

        run_cmd(8'h09, 8'd2, 10'd32, 4'd1, 1, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h00, 8'd0, 10'd32, 4'd1, 1, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h00, 8'd65, 10'd16, 4'd1, 1, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h02, 8'd2, 10'd12, 4'd1, 1, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h03, 8'd2, 10'd8, 4'd3, 1, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h02, 8'd2, 10'd8, 4'd3, 1, 2, 1'b1, 1'b0, 1'b0);
        run_cmd(8'h04, 8'd3, 10'd16, 4'd2, 2, 2, 1'b1, 1'b1, 1'b0);

        pe_hold = 1'b1;
        run_cmd(8'h01, 8'd3, 10'd16, 4'd1, 1, 3, 1'b1, 1'b0, 1'b0);
        pe_hold = 1'b0;

        for (int t = 0; t < 8; t++) begin
            r_instr = 8'($urandom_range(0, 9));
            r_vl = ($urandom_range(0, 9) == 0) ? 8'd70 : 8'($urandom_range(0, 6));
            run_cmd(r_instr, r_vl, sews[$urandom_range(0, 6)], 4'($urandom_range(0, 5)),
                    $urandom_range(1, 3), $urandom_range(1, 4), 1'b1, 1'b0, 1'b0);
        end

        // hung PE trips the watchdog
        run_cmd(8'h00, 8'd2, 10'd32, 4'd1, 1, 1, 1'b1, 1'b0, 1'b1);

        // reset while waiting for the operands of element 2 of 4
        rd_lat = 6; pe_lat = 2;
        @(negedge clk);
        clear_log();
        issue(8'h00, 8'd4, 10'd32, 4'd1);
        for (int k = 0; k < 200 && rd_q.size() < 2; k++) @(negedge clk);
        chk("mid_second_fetch", rd_q.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        clear_log();
        @(negedge clk);
        chk("midrst_ready_rise", {31'd0, cmd_ready}, 32'd1);
        repeat (12) @(negedge clk);
        chk("midrst_no_wb", wb_q_idx.size(), 0);
        chk("midrst_no_done", done_cnt, 0);
        run_cmd(8'h05, 8'd2, 10'd8, 4'd4, 1, 2, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vpe_scheduler.md
VPE_SCHEDULER -- requirements
Module: vpe_scheduler

Interface
REQ-001 SHALL have parameter VLMAX, default 64, giving the maximum vector length in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 80, giving the maximum cycles allowed per processing-element operation.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_instr in 8, cmd_vl in 8, cmd_sew in 10, cmd_vap in 4, which form the command handshake.
REQ-006 SHALL have ports busy out 1, cmd_done out 1, cmd_err out 1, which carry status.
REQ-007 SHALL have ports rd_req out 1, rd_idx out 8, rd_valid in 1, rd_opa in 32, rd_opb in 32, rd_opc in 32, which form the operand fetch interface.
REQ-008 SHALL have ports pe_reset_n out 1, pe_start out 1, pe_done in 1, pe_instr out 8, pe_sew out 10, pe_vap out 4, pe_opa out 32, pe_opb out 32, pe_opc out 32, pe_out in 32, which drive the processing element.
REQ-009 SHALL have ports wb_valid out 1, wb_idx out 8, wb_data out 32, which form the result writeback.

Function
REQ-010 SHALL implement states IDLE, FETCH, WAIT_OPS, EXEC, WB and FINISH.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-012 On accept, SHALL latch instr/vl/sew/vap, clear the index to 0, and go to FETCH.
REQ-013 On accept with cmd_instr>8'h07, or cmd_sew not in {8,16,32}, or (instr in {03,04,05,07} and vap not in {1,2,4}), SHALL pulse cmd_err and cmd_done together for 1 cycle and stay in IDLE.
REQ-014 On accept with cmd_vl=0 or cmd_vl>VLMAX, SHALL go straight to FINISH with no fetch; cmd_err=1 only when cmd_vl>VLMAX.
REQ-015 In FETCH, SHALL pulse rd_req for 1 cycle with rd_idx=index, then go to WAIT_OPS.
REQ-016 In WAIT_OPS, SHALL latch rd_opa/opb/opc into the pe_op* registers on rd_valid and go to EXEC; with no rd_valid it waits indefinitely.
REQ-017 SHALL hold pe_op*, pe_instr, pe_sew and pe_vap stable from EXEC entry until WB exits.
REQ-018 SHALL register pe_done each cycle into done_q; completion is defined as pe_done=1 and done_q=0.
REQ-019 SHALL drive pe_start combinationally as (state==EXEC) and not completion, so start drops in the same cycle completion is seen; a stale pe_done=1 at EXEC entry does not count as completion.
REQ-020 On completion, SHALL capture pe_out into wb_data and go to WB.
REQ-021 In WB, SHALL assert wb_valid=1 for exactly 1 cycle with wb_idx=index.
REQ-022 After WB, if index==vl-1 SHALL go to FINISH, else increment index and go to FETCH.
REQ-023 In FINISH, SHALL pulse cmd_done for 1 cycle and return to IDLE.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL count cycles spent in EXEC with a watchdog; when the count reaches TIMEOUT without completion, it SHALL drive pe_reset_n=0 for 1 cycle, pulse cmd_err and cmd_done, skip writeback, and go to IDLE.
REQ-026 pe_reset_n SHALL otherwise equal the inverse of reset, registered.
REQ-027 The index SHALL be 8 bits and SHALL never wrap, because vl<=VLMAX<=255.
REQ-028 Per-element latency is 1 (FETCH) + read latency + PE latency + 1 (capture) + 1 (WB) cycles.
REQ-029 cmd_valid while busy SHALL be ignored: no accept and no state disturbance.

Reset
REQ-030 While reset=1 at a clock edge, SHALL set state=IDLE, index=0, done_q=0 and watchdog=0.
REQ-031 While reset=1, SHALL drive cmd_ready=0, busy=0, cmd_done=0, cmd_err=0, rd_req=0, rd_idx=0, pe_start=0, pe_instr=0, pe_sew=0, pe_vap=0, pe_op*=0, wb_valid=0, wb_idx=0, wb_data=0 and pe_reset_n=0.
REQ-032 Reset asserted mid-command SHALL abandon the command: no wb_valid and no cmd_done afterwards.
REQ-033 cmd_ready SHALL rise on the first cycle after reset deasserts.

Verification
REQ-034 vadd (00), sew=8, vl=3, opA=32'h01020304, opB=32'h01010101 for every word -> three wb_valid pulses, idx 0,1,2, data 32'h02030405, then one cmd_done with cmd_err=0.
REQ-035 vmul (01), sew=32, vl=1, opA=5, opB=7 -> pe_start held through the multi-cycle op; wb_data=35 at idx 0; pe_start=0 in the completion cycle.
REQ-036 cmd_instr=8'h09 -> cmd_err and cmd_done pulse together; no rd_req; state stays IDLE.
REQ-037 cmd_vl=0 -> cmd_done pulses 2 cycles after accept, with no rd_req and cmd_err=0.
REQ-038 pe_done tied 0 with TIMEOUT=80 -> after 80 EXEC cycles, pe_reset_n=0 for 1 cycle, cmd_err=1 and no wb_valid.
REQ-039 reset asserted during WAIT_OPS of element 2 of 4 -> all outputs at reset values, no further wb_valid, and a new command accepted normally after release.
